sogi_nco: RTL and testbench
===========================

# sogi_nco

Numerically controlled oscillator closing the SOGI-PLL loop: consumes the signed frequency-correction word produced by the loop PI controller and advances a phase accumulator once per sample tick. It synthesises sin/cos of the accumulated phase from a quarter-wave ROM and delivers them on an AXI-Stream master. The sin/cos drive the Park/phase-detector stage and `theta_out` is exported for downstream use. One result is produced per `sample_en` pulse, at full clock-rate throughput.

## Interface
- `DATA_WIDTH`, 32: controller word is `DATA_WIDTH+1` bits signed.
- `PHASE_WIDTH`, 32: accumulator width; one full turn = 2^PHASE_WIDTH.
- `LUT_ADDR`, 10: quarter-wave ROM address bits (N = 2^LUT_ADDR entries).
- `AMP_WIDTH`, 16: signed sin/cos sample width.
- `F_NOM`, 2^30: nominal phase increment (unsigned, PHASE_WIDTH bits).
- `FREQ_SHIFT`, 0: arithmetic right shift applied to `freq_in`.
---
- `Clk` in 1: single clock, all logic on rising edge.
- `Resetn` in 1: reset, asynchronous, active-low.
- `sample_en` in 1: one-cycle sample tick.
- `freq_in` in DATA_WIDTH+1: signed correction from the PI controller, sampled when `sample_en`=1.
- `m_axis_tdata` out 2*AMP_WIDTH: {cos, sin}, both two's complement.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: downstream accept.
- `theta_out` out PHASE_WIDTH: current accumulator value.
- `freq_clamped` out 1: last increment was clamped; updated on each `sample_en`.
- `overrun` out 1: sticky, a result was overwritten before being accepted.

## Operation
- Reset: `theta`=0, all pipeline valids=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `freq_clamped`=0, `overrun`=0. In-flight samples are discarded.
- Increment: inc = F_NOM + (freq_in >>> FREQ_SHIFT), computed signed at PHASE_WIDTH+2 bits.
  - Clamp to [0, 2^(PHASE_WIDTH-1)-1], i.e. no reverse rotation and below Nyquist.
  - `freq_clamped` = 1 if clamping occurred.
- On `sample_en`: pipeline captures the pre-update `theta`, and `theta` <= (theta + inc) mod 2^PHASE_WIDTH. Wrap-around is natural modulo with no flag.
- Decode: q = theta[MSB:MSB-1]; i = next LUT_ADDR bits; lower bits are truncated.
- ROM: L[k] = round((2^(AMP_WIDTH-1)-1)·sin(π/2·(k+0.5)/N)).
- sin by q: 0 → L[i]; 1 → L[~i]; 2 → −L[i]; 3 → −L[~i].
- cos uses the same rule with quadrant q+1 mod 4.
- Output register (AXI-Stream master):
  - Transfer occurs when tvalid & tready.
  - tdata is stable while tvalid=1 and tready=0, unless an overrun occurs.
  - A new result arriving with tvalid=1, tready=0 overwrites tdata, keeps tvalid=1 and sets `overrun`.
  - A new result arriving in a cycle where a transfer occurs loads normally, with no overrun.
  - With no new result, a transfer clears tvalid.
- The phase accumulator never stalls on backpressure, so loop timing is preserved.

## Timing
- Latency: `sample_en` at edge t → tvalid and tdata valid after edge t+3.
  - Stage 1: capture phase and decode.
  - Stage 2: registered ROM read.
  - Stage 3: sign/complement into the output register.
- `theta_out` and `freq_clamped` update at edge t+1.
- Throughput: one `sample_en` per cycle is legal; back-to-back results then appear on consecutive cycles.
- `overrun` and `freq_clamped` are registered outputs; `overrun` clears only on reset.
- Asserting `Resetn` low mid-pipeline clears all state immediately. The first tick after release produces theta=0.

## Configuration
- `SOGI_NCO_COS_EN` defined: cos path and second ROM read port present; tdata = {cos, sin}.
- `SOGI_NCO_COS_EN` undefined: cos path is removed and tdata[2*AMP_WIDTH-1:AMP_WIDTH] = 0. Latency and handshake are unchanged.

## Test plan
- Defaults, `freq_in`=0, 4 ticks, tready=1:
  - `theta_out` = 0x40000000, 0x80000000, 0xC0000000, 0x00000000.
  - sin = 25, 32767, −25, −32767.
  - cos = 32767, −25, −32767, 25 (macro defined).
- Clamping:
  - `freq_in` = −2^31 → `freq_clamped`=1 and `theta_out` frozen.
  - `freq_in` = +2^31 → inc clamped to 0x7FFFFFFF, `freq_clamped`=1.
- Backpressure:
  - tready=0 with one tick → tvalid held 3 edges later and tdata stable for 10 cycles.
  - Second tick completes while still stalled → tdata replaced and `overrun`=1.
  - Ticks continue and `theta_out` advances throughout.
- Simultaneous transfer and load: continuous ticks with tready=1 → one transfer per cycle, `overrun` stays 0.
- Reset mid-pipeline: tick, then assert Resetn low one cycle later → tvalid=0 and theta=0 with no output. After release, the first tick outputs sin=25.
- Macro undefined: repeat the first scenario → cos field reads 0 and sin values are unchanged.

Source files
------------

// File: rtl/sogi_nco.sv
// sogi_nco: SOGI-PLL phase accumulator with quarter-wave sin/cos synthesis and an AXI-Stream master output.
// Build option: define SOGI_NCO_COS_EN to include the cos path; otherwise the cos field of m_axis_tdata is zero.
module sogi_nco #(
    parameter int                     DATA_WIDTH  = 32,
    parameter int                     PHASE_WIDTH = 32,
    parameter int                     LUT_ADDR    = 10,
    parameter int                     AMP_WIDTH   = 16,
    parameter logic [PHASE_WIDTH-1:0] F_NOM       = 32'h4000_0000,
    parameter int                     FREQ_SHIFT  = 0
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic                   sample_en,
    input  logic [DATA_WIDTH:0]    freq_in,
    output logic [2*AMP_WIDTH-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [PHASE_WIDTH-1:0] theta_out,
    output logic                   freq_clamped,
    output logic                   overrun
);
    localparam int N       = 2 ** LUT_ADDR;
    localparam int AMP_MAX = 2 ** (AMP_WIDTH - 1) - 1;
    localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

    // Elaboration-time L[k] = round(AMP_MAX*sin(pi/2*(k+0.5)/N)) via a Q60 Taylor series.
    function automatic logic [AMP_WIDTH-1:0] lut_value(input int k);
        logic signed [127:0] x, x2, term, acc, scaled;
        x    = (PI_Q60 * 128'(2 * k + 1)) >>> (LUT_ADDR + 2);
        x2   = (x * x) >>> 60;
        term = x;
        acc  = x;
        for (int n = 1; n <= 13; n++) begin
            term = ((term * x2) >>> 60) / 128'((2 * n) * (2 * n + 1));
            acc  = (n % 2 == 1) ? acc - term : acc + term;
        end
        scaled = (acc * 128'(AMP_MAX) + (128'sd1 <<< 59)) >>> 60;
        return scaled[AMP_WIDTH-1:0];
    endfunction

    logic [AMP_WIDTH-1:0] rom [N];
    for (genvar k = 0; k < N; k++) begin : g_rom
        localparam logic [AMP_WIDTH-1:0] VAL = lut_value(k);
        assign rom[k] = VAL;
    end

    logic signed [DATA_WIDTH:0]    freq_shifted;
    logic signed [PHASE_WIDTH+1:0] inc_sum;
    logic [PHASE_WIDTH-1:0]        inc;
    logic                          clamp;

    assign freq_shifted = $signed(freq_in) >>> FREQ_SHIFT;
    assign inc_sum      = $signed({2'b00, F_NOM}) + (PHASE_WIDTH+2)'(freq_shifted);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        inc   = inc_sum[PHASE_WIDTH-1:0];
        clamp = 1'b0;
        if (inc_sum[PHASE_WIDTH+1]) begin
            inc   = '0;
            clamp = 1'b1;
        end else if (|inc_sum[PHASE_WIDTH:PHASE_WIDTH-1]) begin
            inc   = {1'b0, {(PHASE_WIDTH-1){1'b1}}};
            clamp = 1'b1;
        end
    end

    logic [PHASE_WIDTH-1:0] theta;
    logic                   s1_valid, s2_valid;
    logic [1:0]             s1_q, cos_q;
    logic [LUT_ADDR-1:0]    s1_i;
    logic [AMP_WIDTH-1:0]   sin_mag, sin_val, cos_val;
    logic                   sin_neg;

    // Stage 1: advance the accumulator and decode the pre-update phase.
    always_ff @(posedge Clk or negedge Resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!Resetn) begin
            theta        <= '0;
            freq_clamped <= 1'b0;
            s1_valid     <= 1'b0;
            s1_q         <= '0;
            s1_i         <= '0;
        end else begin
            s1_valid <= sample_en;
            if (sample_en) begin
                theta        <= theta + inc;
                freq_clamped <= clamp;
                s1_q         <= theta[PHASE_WIDTH-1 -: 2];
                s1_i         <= theta[PHASE_WIDTH-3 -: LUT_ADDR];
            end
        end
    end

    assign cos_q = s1_q + 2'd1;

    // Stage 2: registered ROM read; odd quadrants read the mirrored index.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            s2_valid <= 1'b0;
            sin_mag  <= '0;
            sin_neg  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                sin_mag <= rom[s1_q[0] ? ~s1_i : s1_i];
                sin_neg <= s1_q[1];
            end
        end
    end

    assign sin_val = sin_neg ? -sin_mag : sin_mag;

`ifdef SOGI_NCO_COS_EN
    logic [AMP_WIDTH-1:0] cos_mag;
    logic                 cos_neg;

    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            cos_mag <= '0;
            cos_neg <= 1'b0;
        end else if (s1_valid) begin
            cos_mag <= rom[cos_q[0] ? ~s1_i : s1_i];
            cos_neg <= cos_q[1];
        end
    end

    assign cos_val = cos_neg ? -cos_mag : cos_mag;
`else
    logic unused_cos_q;
    assign unused_cos_q = ^cos_q;
    assign cos_val      = '0;
`endif

    // Stage 3: output register; a result arriving during a stall overwrites and flags overrun.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            overrun       <= 1'b0;
        end else if (s2_valid) begin
            m_axis_tdata  <= {cos_val, sin_val};
            m_axis_tvalid <= 1'b1;
            if (m_axis_tvalid && !m_axis_tready)
                overrun <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    assign theta_out = theta;

endmodule

// File: tb/tb_sogi_nco.sv
// tb_sogi_nco: directed and randomized checks of sogi_nco against a cycle-level behavioural model.
// The model computes the sine table with real arithmetic and tracks results by their due cycle.
module tb_sogi_nco;
    localparam int  DW = 32;
    localparam int  PW = 32;
    localparam int  AW = 16;
    localparam int  N  = 1024;
    localparam real PI = 3.14159265358979323846;

    logic            Clk = 1'b0;
    logic            Resetn = 1'b0;
    logic            sample_en = 1'b0;
    logic [DW:0]     freq_in = '0;
    logic            m_axis_tready = 1'b0;
    logic [2*AW-1:0] m_axis_tdata;
    logic            m_axis_tvalid;
    logic [PW-1:0]   theta_out;
    logic            freq_clamped;
    logic            overrun;

    always #5 Clk = ~Clk;

    sogi_nco dut (
        .Clk(Clk), .Resetn(Resetn), .sample_en(sample_en), .freq_in(freq_in),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .theta_out(theta_out), .freq_clamped(freq_clamped), .overrun(overrun)
    );

    typedef struct {
        longint      due;
        logic [31:0] word;
    } res_t;

    int          total = 0;
    int          bad   = 0;
    int          lut [N];
    longint      theta_m;
    longint      cyc = 0;
    bit          exp_valid, exp_ovr, exp_clamped;
    logic [31:0] exp_data;
    res_t        pend [$];
    int          got_sin [$];
    int          got_cos [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wave(input longint q, input longint i);
        int m;
        m = lut[int'((q % 2 == 1) ? (N - 1 - i) : i)];
        return 16'((q >= 2) ? -m : m);
    endfunction

    function automatic logic [31:0] result_of(input longint th);
        longint      q, i;
        logic [15:0] s;
        q = th / (64'sd1 << 30);
        i = (th % (64'sd1 << 30)) / (64'sd1 << 20);
        s = wave(q, i);
`ifdef SOGI_NCO_COS_EN
        return {wave((q + 1) % 4, i), s};
`else
        return {16'h0000, s};
`endif
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".tvalid"}, 64'(m_axis_tvalid), 64'(exp_valid));
        check({tag, ".tdata"}, 64'(m_axis_tdata), 64'(exp_data));
        check({tag, ".theta"}, 64'(theta_out), 64'(theta_m));
        check({tag, ".clamped"}, 64'(freq_clamped), 64'(exp_clamped));
        check({tag, ".overrun"}, 64'(overrun), 64'(exp_ovr));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    task automatic cycle(input bit se, input longint fin, input bit rdy, input string tag);
        longint inc;
        res_t   r;
        sample_en     = se;
        freq_in       = fin[DW:0];
        m_axis_tready = rdy;
        @(posedge Clk);
        if (pend.size() > 0 && pend[0].due == cyc) begin
            r = pend.pop_front();
            if (exp_valid && !rdy) exp_ovr = 1'b1;
            exp_valid = 1'b1;
            exp_data  = r.word;
        end else if (exp_valid && rdy) begin
            exp_valid = 1'b0;
        end
        if (se) begin
            inc         = (64'sd1 << 30) + fin;
            exp_clamped = 1'b0;
            if (inc < 0) begin
                inc = 0;
                exp_clamped = 1'b1;
            end else if (inc > 64'sd2147483647) begin
                inc = 64'sd2147483647;
                exp_clamped = 1'b1;
            end
            pend.push_back('{cyc + 2, result_of(theta_m)});
            theta_m = (theta_m + inc) % (64'sd1 << 32);
        end
        cyc++;
        #1;
        check_model(tag);
        if (m_axis_tvalid && rdy) begin
            got_sin.push_back(int'($signed(m_axis_tdata[15:0])));
            got_cos.push_back(int'($signed(m_axis_tdata[31:16])));
        end
    endtask

    task automatic do_reset(input string tag);
        Resetn        = 1'b0;
        sample_en     = 1'b0;
        m_axis_tready = 1'b0;
        pend.delete();
        theta_m     = 0;
        exp_valid   = 1'b0;
        exp_ovr     = 1'b0;
        exp_clamped = 1'b0;
        exp_data    = '0;
        #1;
        check_model({tag, ".async"});
        repeat (2) @(posedge Clk);
        #1;
        check_model(tag);
        Resetn = 1'b1;
    endtask

    initial begin
        longint theta_exp [4] = '{64'h4000_0000, 64'h8000_0000, 64'hC000_0000, 64'h0};
        int     sin_exp [4]   = '{25, 32767, -25, -32767};
        int     cos_exp [4]   = '{32767, -25, -32767, 25};
        longint fin;

        for (int k = 0; k < N; k++)
            lut[k] = $rtoi($floor(32767.0 * $sin(PI / 2.0 * (real'(k) + 0.5) / real'(N)) + 0.5));

        do_reset("reset");

        // Nominal rate: quarter-turn per tick.
        got_sin.delete();
        got_cos.delete();
        for (int t = 0; t < 4; t++) begin
            cycle(1'b1, 0, 1'b1, "nominal");
            check("nominal.theta_const", 64'(theta_out), 64'(theta_exp[t]));
        end
        repeat (5) cycle(1'b0, 0, 1'b1, "nominal.drain");
        check("nominal.count", 64'(got_sin.size()), 64'd4);
        for (int t = 0; t < 4 && t < got_sin.size(); t++) begin
            check("nominal.sin", 64'(got_sin[t]), 64'(sin_exp[t]));
`ifdef SOGI_NCO_COS_EN
            check("nominal.cos", 64'(got_cos[t]), 64'(cos_exp[t]));
`else
            check("nominal.cos_zero", 64'(got_cos[t]), 64'd0);
            if (t == 0) check("nominal.cos_unused", 64'(cos_exp[t]), 64'd32767);
`endif
        end

        // Clamping at both ends.
        cycle(1'b1, -(64'sd1 << 31), 1'b1, "clamp.neg");
        check("clamp.neg.flag", 64'(freq_clamped), 64'd1);
        check("clamp.neg.frozen", 64'(theta_out), 64'h0);
        cycle(1'b1, (64'sd1 << 31), 1'b1, "clamp.pos");
        check("clamp.pos.flag", 64'(freq_clamped), 64'd1);
        check("clamp.pos.theta", 64'(theta_out), 64'h7FFF_FFFF);
        cycle(1'b1, 0, 1'b1, "clamp.clear");
        check("clamp.clear.flag", 64'(freq_clamped), 64'd0);
        repeat (4) cycle(1'b0, 0, 1'b1, "clamp.drain");

        // Continuous ticks with tready high: one transfer per cycle, no overrun.
        do_reset("reset2");
        got_sin.delete();
        got_cos.delete();
        for (int t = 0; t < 20; t++)
            cycle(1'b1, longint'($urandom_range(0, 2000)) - 1000, 1'b1, "stream");
        repeat (4) cycle(1'b0, 0, 1'b1, "stream.drain");
        check("stream.xfers", 64'(got_sin.size()), 64'd20);
        check("stream.overrun", 64'(overrun), 64'd0);

        // Reset one cycle after a tick: the in-flight sample is discarded.
        cycle(1'b1, 0, 1'b1, "midrst.tick");
        cycle(1'b0, 0, 1'b1, "midrst.wait");
        do_reset("midrst");
        check("midrst.tvalid", 64'(m_axis_tvalid), 64'd0);
        check("midrst.theta", 64'(theta_out), 64'd0);
        got_sin.delete();
        got_cos.delete();
        cycle(1'b1, 0, 1'b1, "midrst.first");
        repeat (4) cycle(1'b0, 0, 1'b1, "midrst.drain");
        check("midrst.count", 64'(got_sin.size()), 64'd1);
        if (got_sin.size() > 0) check("midrst.sin", 64'(got_sin[0]), 64'd25);

        // Backpressure: hold, then overwrite while stalled.
        do_reset("reset3");
        cycle(1'b1, 0, 1'b0, "bp.tick");
        repeat (12) cycle(1'b0, 0, 1'b0, "bp.hold");
        check("bp.held", 64'(m_axis_tvalid), 64'd1);
        cycle(1'b1, 0, 1'b0, "bp.tick2");
        repeat (3) cycle(1'b0, 0, 1'b0, "bp.wait");
        check("bp.overrun", 64'(overrun), 64'd1);
`ifdef SOGI_NCO_COS_EN
        check("bp.tdata", 64'(m_axis_tdata), 64'hFFE7_7FFF);
`else
        check("bp.tdata", 64'(m_axis_tdata), 64'h0000_7FFF);
`endif
        repeat (6) cycle(1'b1, 0, 1'b0, "bp.ticking");
        check("bp.theta_runs", 64'(theta_out), 64'h0000_0000);
        repeat (5) cycle(1'b0, 0, 1'b1, "bp.release");

        // Randomized traffic including extreme corrections and random backpressure.
        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 9))
                0:       fin = -(64'sd1 << 31);
                1:       fin = (64'sd1 << 31);
                2:       fin = -(64'sd1 << 30) - longint'($urandom_range(0, 1000));
                default: fin = (longint'($urandom_range(0, 2000)) - 1000) * 64'sd1000000;
            endcase
            cycle(1'($urandom_range(0, 1)), fin, 1'($urandom_range(0, 3) != 0), "rand");
        end
        repeat (5) cycle(1'b0, 0, 1'b1, "rand.drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
